// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: shared definitions for the JTAG TAP initiator.
// Holds the command opcodes, the TMS preamble/postamble patterns that walk
// the target TAP from Run-Test/Idle into Shift-IR/Shift-DR and back, and
// the main FSM state enum. Patterns are stored LSB-first: bit 0 is the TMS
// value presented on the first TCK of the sequence.
package jtag_master_pkg;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_IR    = 2'b01;
  localparam logic [1:0] OP_DR    = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  // TMS 1,1,1,1,1,0 : five ones reach Test-Logic-Reset, the zero parks in RTI
  localparam logic [5:0] PRE_TMS_RESET = 6'b011111;
  // TMS 1,1,0,0 : RTI -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
  localparam logic [5:0] PRE_TMS_IR    = 6'b000011;
  // TMS 1,0,0 : RTI -> Select-DR -> Capture-DR -> Shift-DR
  localparam logic [5:0] PRE_TMS_DR    = 6'b000001;
  // Index of the final preamble TCK (length minus one)
  localparam logic [2:0] PRE_LAST_RESET = 3'd5;
  localparam logic [2:0] PRE_LAST_IR    = 3'd3;
  localparam logic [2:0] PRE_LAST_DR    = 3'd2;

  // TMS 1,0 : Exit1 -> Update -> RTI (two TCKs)
  localparam logic [1:0] POST_TMS  = 2'b01;
  localparam logic [2:0] POST_LAST = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [5:0] pre_tms(input logic [1:0] op);
    case (op)
      OP_RESET: pre_tms = PRE_TMS_RESET;
      OP_IR:    pre_tms = PRE_TMS_IR;
      OP_DR:    pre_tms = PRE_TMS_DR;
      default:  pre_tms = 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] pre_last(input logic [1:0] op);
    case (op)
      OP_RESET: pre_last = PRE_LAST_RESET;
      OP_IR:    pre_last = PRE_LAST_IR;
      OP_DR:    pre_last = PRE_LAST_DR;
      default:  pre_last = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: TCK divider for the JTAG master.
// Each TCK phase lasts DIV clk cycles, low phase first. The strobes flag the
// clk edge at which tck is about to toggle, so the FSM can update TMS/TDI
// together with the falling edge and sample TDO together with the rising one.
// Ports:
//   clk_i      system clock
//   reset_i    synchronous active-high reset
//   run_i      high while a command is running; low clears and holds tck at 0
//   tck_o      JTAG clock (registered)
//   rise_en_o  tck goes 0->1 at the coming clk edge
//   fall_en_o  tck goes 1->0 at the coming clk edge
module jtag_tck_gen #(
  parameter int DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  output logic tck_o,
  output logic rise_en_o,
  output logic fall_en_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tck_q;
  logic          phase_end_s;

  assign phase_end_s = run_i && (cnt_q == CNT_LAST);
  assign rise_en_o   = phase_end_s && !tck_q;
  assign fall_en_o   = phase_end_s && tck_q;
  assign tck_o       = tck_q;

  // Phase counter; toggles tck at the end of every DIV-cycle phase
  always_ff @(posedge clk_i) begin
    if (reset_i || !run_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      tck_q <= !tck_q;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/jtag_master.sv
// jtag_master: clock-enabled JTAG TAP initiator (command/response engine).
// Accepts one command at a time (TAP reset, IR shift, DR shift, idle clocks),
// plays the TMS/TDI sequence on a divided TCK and returns the captured TDO
// bits right-aligned in rsp_data with a one-cycle rsp_valid pulse.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_op/cmd_len/cmd_data     opcode, bit count minus one, TDI payload LSB first
//   rsp_valid/rsp_data          completion pulse and captured TDO bits
//   busy                        command in progress (inverse of cmd_ready)
//   tck/tms/tdi/tdo             JTAG pins; tdo is synchronous to clk
module jtag_master #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);
  import jtag_master_pkg::*;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [4:0]  len_q;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [4:0]  bit_q;
  logic [2:0]  seq_q;
  logic        tms_q;
  logic        tdi_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;

  logic [4:0]  bit_d;
  logic [2:0]  seq_d;
  logic [5:0]  pre_cmd_s;
  logic [5:0]  pre_op_s;
  logic        run_s;
  logic        rise_en_s;
  logic        fall_en_s;

  assign bit_d     = bit_q + 5'd1;
  assign seq_d     = seq_q + 3'd1;
  assign pre_cmd_s = pre_tms(cmd_op);
  assign pre_op_s  = pre_tms(op_q);
  assign run_s     = (state_q == ST_PRE) || (state_q == ST_SHIFT) || (state_q == ST_POST);

  jtag_tck_gen #(.DIV(DIV)) u_tck_gen (
    .clk_i     (clk),
    .reset_i   (reset),
    .run_i     (run_s),
    .tck_o     (tck),
    .rise_en_o (rise_en_s),
    .fall_en_o (fall_en_s)
  );

  assign cmd_ready = ready_q;
  assign busy      = !ready_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // Main FSM: command latch, TMS sequencer, TDI shift-out and TDO capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RESET;
      len_q       <= 5'd0;
      tx_q        <= 32'd0;
      rx_q        <= 32'd0;
      bit_q       <= 5'd0;
      seq_q       <= 3'd0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            len_q   <= cmd_len;
            tx_q    <= cmd_data;
            rx_q    <= 32'd0;
            bit_q   <= 5'd0;
            seq_q   <= 3'd0;
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            // The accept edge acts as the first falling edge: present TMS now
            if (cmd_op == OP_IDLE) begin
              state_q <= ST_SHIFT;
              tms_q   <= 1'b0;
            end else begin
              state_q <= ST_PRE;
              tms_q   <= pre_cmd_s[0];
            end
          end
        end
        ST_PRE: begin
          if (fall_en_s) begin
            if (seq_q == pre_last(op_q)) begin
              if (op_q == OP_RESET) begin
                state_q     <= ST_DONE;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_q;
              end else begin
                state_q <= ST_SHIFT;
                // A single-bit shift is also the exit bit
                tms_q   <= (len_q == 5'd0);
                tdi_q   <= tx_q[0];
              end
            end else begin
              seq_q <= seq_d;
              tms_q <= pre_op_s[seq_d];
            end
          end
        end
        ST_SHIFT: begin
          // Capture into the bit's own position: right-aligned, upper bits stay 0
          if (rise_en_s && (op_q != OP_IDLE)) begin
            rx_q[bit_q] <= tdo;
          end
          if (fall_en_s) begin
            if (bit_q == len_q) begin
              tdi_q <= 1'b0;
              if (op_q == OP_IDLE) begin
                state_q     <= ST_DONE;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= rx_q;
              end else begin
                state_q <= ST_POST;
                seq_q   <= 3'd0;
                tms_q   <= POST_TMS[0];
              end
            end else begin
              bit_q <= bit_d;
              tdi_q <= (op_q == OP_IDLE) ? 1'b0 : tx_q[bit_d];
              tms_q <= (op_q != OP_IDLE) && (bit_d == len_q);
            end
          end
        end
        ST_POST: begin
          if (fall_en_s) begin
            if (seq_q == POST_LAST) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rx_q;
            end else begin
              seq_q <= seq_d;
              tms_q <= POST_TMS[1];
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed bench for jtag_master with DIV=2 and a behavioural
// TAP target (8-bit IR capturing 0x01, 32-bit ER1 data register at IR=0x32,
// 1-bit bypass otherwise).
module tb_jtag_master;

  localparam int DIV = 2;
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5,
                 PSDR = 6, EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10,
                 SHIR = 11, EX1IR = 12, PSIR = 13, EX2IR = 14, UPIR = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_len = 5'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready, rsp_valid, busy, tck, tms, tdi;
  logic [31:0] rsp_data;
  logic        tdo = 1'b0;

  int total = 0;
  int bad = 0;
  int rise_cnt = 0;
  int rsp_cnt = 0;
  logic [63:0] tms_log = 64'h0;
  logic [63:0] tdi_log = 64'h0;

  int          tap_st = SHDR;
  logic [7:0]  tap_ir = 8'hFF;
  logic [7:0]  ir_sr = 8'h00;
  logic [31:0] dr_sr = 32'h0;
  logic [31:0] er1 = 32'h0;

  jtag_master #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  always #5 clk = ~clk;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PSDR;
      PSDR:  return m ? EX2DR : PSDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PSIR;
      PSIR:  return m ? EX2IR : PSIR;
      EX2IR: return m ? UPIR  : SHIR;
      UPIR:  return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  // TAP target: log pins and act on every TCK rising edge
  always @(posedge tck) begin
    if (rise_cnt < 64) begin
      tms_log[rise_cnt] = tms;
      tdi_log[rise_cnt] = tdi;
    end
    rise_cnt = rise_cnt + 1;
    case (tap_st)
      TLR:   tap_ir = 8'hFF;
      CAPIR: ir_sr = 8'h01;
      SHIR:  ir_sr = {tdi, ir_sr[7:1]};
      UPIR:  tap_ir = ir_sr;
      CAPDR: dr_sr = (tap_ir == 8'h32) ? er1 : 32'h0;
      SHDR:  dr_sr = (tap_ir == 8'h32) ? {tdi, dr_sr[31:1]} : {31'h0, tdi};
      UPDR:  if (tap_ir == 8'h32) er1 = dr_sr;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  // TAP target output changes on the falling TCK edge
  always @(negedge tck) begin
    tdo = (tap_st == SHIR) ? ir_sr[0] : ((tap_st == SHDR) ? dr_sr[0] : 1'b0);
  end

  always @(posedge clk) if (rsp_valid === 1'b1) rsp_cnt = rsp_cnt + 1;

  // Issue one command and return the accept-edge-to-response latency in clk
  // edges (the edge that samples rsp_valid high). Inputs are scrambled after
  // accept so that only latched values can produce the right result.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, output int lat);
    @(negedge clk);
    cmd_op = op; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
    rise_cnt = 0; tms_log = 64'h0; tdi_log = 64'h0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~op; cmd_len = ~len; cmd_data = ~data;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    lat = lat + 1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (tck !== 1'b0) begin bad++; $display("FAIL rst_tck: got %b want 0", tck); end
    total++; if (tms !== 1'b1) begin bad++; $display("FAIL rst_tms: got %b want 1", tms); end
    total++; if (tdi !== 1'b0) begin bad++; $display("FAIL rst_tdi: got %b want 0", tdi); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    reset = 1'b0;
  endtask

  task automatic test_tap_reset;
    int lat;
    run_cmd(2'b00, 5'd0, 32'hFFFF_FFFF, lat);
    total++; if (lat != 25) begin bad++; $display("FAIL op00_latency: got %0d want 25", lat); end
    total++; if (rise_cnt != 6) begin bad++; $display("FAIL op00_tck: got %0d want 6", rise_cnt); end
    total++; if (tms_log[5:0] !== 6'b011111) begin bad++; $display("FAIL op00_tms: got %b want 011111", tms_log[5:0]); end
    total++; if (tdi_log[5:0] !== 6'b000000) begin bad++; $display("FAIL op00_tdi: got %b want 000000", tdi_log[5:0]); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL op00_rsp: got %h want 0", rsp_data); end
    total++; if (tap_st != RTI) begin bad++; $display("FAIL op00_model_rti: got %0d want %0d", tap_st, RTI); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL op00_ready_in_done: got %b want 0", cmd_ready); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL op00_pulse_width: got %b want 0", rsp_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL op00_ready_after: got %b want 1", cmd_ready); end
  endtask

  task automatic test_shift_ir;
    int lat;
    run_cmd(2'b01, 5'd7, 32'h0000_0032, lat);
    total++; if (lat != 57) begin bad++; $display("FAIL ir_latency: got %0d want 57", lat); end
    total++; if (rise_cnt != 14) begin bad++; $display("FAIL ir_tck: got %0d want 14", rise_cnt); end
    total++; if (tms_log[13:0] !== {2'b01, 8'h80, 4'b0011}) begin bad++; $display("FAIL ir_tms: got %b want %b", tms_log[13:0], {2'b01, 8'h80, 4'b0011}); end
    total++; if (tdi_log[13:0] !== {2'b00, 8'h32, 4'b0000}) begin bad++; $display("FAIL ir_tdi: got %b want %b", tdi_log[13:0], {2'b00, 8'h32, 4'b0000}); end
    total++; if (rsp_data !== 32'h0000_0001) begin bad++; $display("FAIL ir_rsp: got %h want 00000001", rsp_data); end
    total++; if (tap_ir !== 8'h32) begin bad++; $display("FAIL ir_model_ir: got %h want 32", tap_ir); end
  endtask

  task automatic test_shift_dr32;
    int lat;
    er1 = 32'h1234_5678;
    run_cmd(2'b10, 5'd31, 32'hDEAD_BEEF, lat);
    total++; if (lat != 149) begin bad++; $display("FAIL dr32_latency: got %0d want 149", lat); end
    total++; if (rise_cnt != 37) begin bad++; $display("FAIL dr32_tck: got %0d want 37", rise_cnt); end
    total++; if (tms_log[36:0] !== {2'b01, 1'b1, 31'h0, 3'b001}) begin bad++; $display("FAIL dr32_tms: got %h want %h", tms_log[36:0], {2'b01, 1'b1, 31'h0, 3'b001}); end
    total++; if (tdi_log[36:0] !== {2'b00, 32'hDEAD_BEEF, 3'b000}) begin bad++; $display("FAIL dr32_tdi: got %h want %h", tdi_log[36:0], {2'b00, 32'hDEAD_BEEF, 3'b000}); end
    total++; if (rsp_data !== 32'h1234_5678) begin bad++; $display("FAIL dr32_rsp: got %h want 12345678", rsp_data); end
    total++; if (er1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dr32_model_dr: got %h want deadbeef", er1); end
  endtask

  task automatic test_shift_dr4;
    int lat;
    er1 = 32'hA5A5_A5A5;
    run_cmd(2'b10, 5'd3, 32'h0000_000F, lat);
    total++; if (lat != 37) begin bad++; $display("FAIL dr4_latency: got %0d want 37", lat); end
    total++; if (tms_log[8:0] !== {2'b01, 4'b1000, 3'b001}) begin bad++; $display("FAIL dr4_tms: got %b want %b", tms_log[8:0], {2'b01, 4'b1000, 3'b001}); end
    total++; if (tdi_log[8:0] !== {2'b00, 4'hF, 3'b000}) begin bad++; $display("FAIL dr4_tdi: got %b want %b", tdi_log[8:0], {2'b00, 4'hF, 3'b000}); end
    total++; if (rsp_data !== 32'h0000_0005) begin bad++; $display("FAIL dr4_rsp: got %h want 00000005", rsp_data); end
    total++; if (er1 !== 32'hFA5A_5A5A) begin bad++; $display("FAIL dr4_model_dr: got %h want fa5a5a5a", er1); end
  endtask

  task automatic test_idle_clocks;
    int lat;
    run_cmd(2'b11, 5'd9, 32'hFFFF_FFFF, lat);
    total++; if (lat != 41) begin bad++; $display("FAIL idle_latency: got %0d want 41", lat); end
    total++; if (rise_cnt != 10) begin bad++; $display("FAIL idle_tck: got %0d want 10", rise_cnt); end
    total++; if (tms_log[9:0] !== 10'h0) begin bad++; $display("FAIL idle_tms: got %b want 0", tms_log[9:0]); end
    total++; if (tdi_log[9:0] !== 10'h0) begin bad++; $display("FAIL idle_tdi: got %b want 0", tdi_log[9:0]); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL idle_rsp: got %h want 0", rsp_data); end
    total++; if (tap_st != RTI) begin bad++; $display("FAIL idle_model_rti: got %0d want %0d", tap_st, RTI); end
  endtask

  task automatic test_back_to_back;
    int k;
    int lat;
    @(negedge clk);
    cmd_op = 2'b11; cmd_len = 5'd1; cmd_data = 32'h0; cmd_valid = 1'b1;
    @(negedge clk);
    // Second command waits on the handshake while the first one runs
    cmd_op = 2'b10; cmd_len = 5'd7; cmd_data = 32'h0000_003C;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    total++; if (k + 1 != 9) begin bad++; $display("FAIL b2b_first_latency: got %0d want 9", k + 1); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_done: got %b want 0", cmd_ready); end
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_gap: got %b want 1", cmd_ready); end
    total++; if (tck !== 1'b0) begin bad++; $display("FAIL b2b_idle_tck: got %b want 0", tck); end
    rise_cnt = 0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    lat = lat + 1;
    total++; if (lat != 53) begin bad++; $display("FAIL b2b_second_latency: got %0d want 53", lat); end
    total++; if (rsp_data !== 32'h0000_005A) begin bad++; $display("FAIL b2b_rsp: got %h want 0000005a", rsp_data); end
    total++; if (er1 !== 32'h3CFA_5A5A) begin bad++; $display("FAIL b2b_model_dr: got %h want 3cfa5a5a", er1); end
  endtask

  task automatic test_reset_mid;
    int k;
    int lat;
    int rsp_before;
    @(negedge clk);
    cmd_op = 2'b10; cmd_len = 5'd31; cmd_data = 32'hCAFE_F00D; cmd_valid = 1'b1;
    rise_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    // Three preamble rises, then shift bits 0..5: the ninth rise is bit 5
    k = 0;
    while (rise_cnt < 9 && k < 200) begin @(negedge clk); k++; end
    total++; if (rise_cnt != 9) begin bad++; $display("FAIL mid_reach_bit5: got %0d want 9", rise_cnt); end
    total++; if (tck !== 1'b1) begin bad++; $display("FAIL mid_tck_high_before: got %b want 1", tck); end
    rsp_before = rsp_cnt;
    reset = 1'b1;
    cmd_op = 2'b11; cmd_len = 5'd0; cmd_data = 32'h0; cmd_valid = 1'b1;
    @(negedge clk);
    total++; if (tck !== 1'b0) begin bad++; $display("FAIL mid_tck: got %b want 0", tck); end
    total++; if (tms !== 1'b1) begin bad++; $display("FAIL mid_tms: got %b want 1", tms); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL mid_rsp_data: got %h want 0", rsp_data); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rsp_valid: got %b want 0", rsp_valid); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_accept_after_reset: got %b want 1", busy); end
    cmd_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    lat = lat + 1;
    total++; if (lat != 5) begin bad++; $display("FAIL mid_second_latency: got %0d want 5", lat); end
    total++; if (rsp_cnt != rsp_before) begin bad++; $display("FAIL mid_no_rsp_for_aborted: got %0d want %0d", rsp_cnt, rsp_before); end
    @(negedge clk);
    total++; if (rsp_cnt != rsp_before + 1) begin bad++; $display("FAIL mid_one_rsp: got %0d want %0d", rsp_cnt, rsp_before + 1); end
  endtask

  initial begin
    test_reset();
    test_tap_reset();
    test_shift_ir();
    test_shift_dr32();
    test_shift_dr4();
    test_idle_clocks();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
